// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and helpers for the register-file sequencer/arbiter.
package reg_file_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    INIT  = 2'd1,
    SERVE = 2'd2
  } state_t;

  function automatic int unsigned depth_of(input int unsigned width_addr);
    return 32'd1 << width_addr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// past the winner only when the granted transfer actually completes.
module rr_arbiter
  import reg_file_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_r;
  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;
  logic          found_s;
  logic [NREQ-1:0] grant_s;
  logic [IW-1:0] idx_s;

  // first requesting index at or above the pointer, modulo NREQ
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s = {1'b0, ptr_r} + (IW+1)'(i);
      if (sum_s >= (IW+1)'(NREQ)) begin
        cand_s = IW'(sum_s - (IW+1)'(NREQ));
      end else begin
        cand_s = IW'(sum_s);
      end
      if (!found_s && req[cand_s]) begin
        grant_s[cand_s] = 1'b1;
        idx_s           = cand_s;
        found_s         = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // pointer moves past the winner on a completed transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (idx_s == IW'(NREQ-1)) ? '0 : idx_s + IW'(1);
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;

endmodule

// File: rtl/reg_file_ctrl.sv
// Sequencer in front of a single-port register file: zero-fill sweep after
// reset/clear, then round-robin sharing of the port with registered read data.
module reg_file_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int WIDTH_ADDR   = 4,
  parameter int WIDTH_VECTOR = 8,
  parameter int N            = 32,
  parameter int NREQ         = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clear,
  output logic                           init_done,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ*WIDTH_ADDR-1:0]     req_addr,
  input  logic [NREQ*WIDTH_VECTOR*N-1:0] req_wdata,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [WIDTH_VECTOR*N-1:0]      rsp_data,
  output logic                           rf_we,
  output logic [WIDTH_ADDR-1:0]          rf_addr,
  output logic [WIDTH_VECTOR*N-1:0]      rf_wdata,
  input  logic [WIDTH_VECTOR*N-1:0]      rf_rdata
);

  localparam int W  = WIDTH_VECTOR * N;
  localparam int IW = $clog2(NREQ);
  localparam logic [WIDTH_ADDR-1:0] LAST_ADDR = WIDTH_ADDR'(depth_of(WIDTH_ADDR) - 1);

  state_t                  state_r;
  logic [WIDTH_ADDR-1:0]   cnt_r;
  logic [WIDTH_ADDR-1:0]   addr_r;
  logic                    init_done_r;
  logic [NREQ-1:0]         rsp_valid_r;
  logic [W-1:0]            rsp_data_r;

  logic [NREQ-1:0]         arb_req_s;
  logic [NREQ-1:0]         grant_s;
  logic [IW-1:0]           gidx_s;
  logic                    xfer_s;
  logic                    rf_we_s;
  logic [WIDTH_ADDR-1:0]   rf_addr_s;
  logic [W-1:0]            rf_wdata_s;

  // a clear cycle performs no transfer
  always_comb begin
    if (state_r == SERVE && !clear) begin
      arb_req_s = req_valid;
    end else begin
      arb_req_s = '0;
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (arb_req_s),
    .advance   (xfer_s),
    .grant     (grant_s),
    .grant_idx (gidx_s)
  );

  assign xfer_s = |grant_s;

  // register-file port mux: sweep, granted requester, or idle with address held
  always_comb begin
    rf_we_s    = 1'b0;
    rf_addr_s  = addr_r;
    rf_wdata_s = '0;
    case (state_r)
      INIT: begin
        rf_we_s   = 1'b1;
        rf_addr_s = cnt_r;
      end
      SERVE: begin
        if (xfer_s) begin
          rf_we_s    = req_we[gidx_s];
          rf_addr_s  = req_addr[gidx_s*WIDTH_ADDR +: WIDTH_ADDR];
          rf_wdata_s = req_wdata[gidx_s*W +: W];
        end else begin
          rf_we_s = 1'b0;
        end
      end
      default: begin
        rf_we_s = 1'b0;
      end
    endcase
  end

  // boot/sweep/serve sequencing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= BOOT;
      cnt_r       <= '0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r     <= INIT;
          cnt_r       <= '0;
          init_done_r <= 1'b0;
        end
        INIT: begin
          if (clear) begin
            cnt_r <= '0;
          end else if (cnt_r == LAST_ADDR) begin
            cnt_r       <= '0;
            state_r     <= SERVE;
            init_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + WIDTH_ADDR'(1);
          end
        end
        SERVE: begin
          if (clear) begin
            state_r     <= INIT;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= BOOT;
          cnt_r       <= '0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // last driven address, held while the port is idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r <= '0;
    end else begin
      addr_r <= rf_addr_s;
    end
  end

  // read data captured on the transfer edge, strobed to the reader next cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
    end else if (xfer_s && !rf_we_s) begin
      rsp_valid_r <= grant_s;
      rsp_data_r  <= rf_rdata;
    end else begin
      rsp_valid_r <= '0;
    end
  end

  assign init_done = init_done_r;
  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rf_we     = rf_we_s;
  assign rf_addr   = rf_addr_s;
  assign rf_wdata  = rf_wdata_s;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a behavioural single-port register file.
module tb_reg_file_ctrl;

  localparam int WA   = 4;
  localparam int WV   = 8;
  localparam int NB   = 32;
  localparam int NREQ = 2;
  localparam int W    = WV * NB;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  clear;
  logic                  init_done;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*WA-1:0]    req_addr;
  logic [NREQ*W-1:0]     req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic [W-1:0]          rsp_data;
  logic                  rf_we;
  logic [WA-1:0]         rf_addr;
  logic [W-1:0]          rf_wdata;
  logic [W-1:0]          rf_rdata;

  logic [W-1:0] mem [16];
  logic [W-1:0] pat_a;
  logic [W-1:0] pat_b;
  logic [1:0]   exp_g [4];
  logic [1:0]   prev_g;

  int checks = 0;
  int errors = 0;

  reg_file_ctrl #(.WIDTH_ADDR(WA), .WIDTH_VECTOR(WV), .N(NB), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata)
  );

  always #5 clk = ~clk;

  assign rf_rdata = mem[rf_addr];

  always @(posedge clk) begin
    if (rf_we) mem[rf_addr] <= rf_wdata;
  end

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_we"},    W'(rf_we),     W'(1'b0));
    check({tag, "_addr"},  W'(rf_addr),   W'(4'd0));
    check({tag, "_wdata"}, rf_wdata,      W'(1'b0));
    check({tag, "_ready"}, W'(req_ready), W'(2'b00));
    check({tag, "_done"},  W'(init_done), W'(1'b0));
    check({tag, "_rspv"},  W'(rsp_valid), W'(2'b00));
    check({tag, "_rspd"},  rsp_data,      W'(1'b0));
  endtask

  initial begin
    pat_a = {32{8'hA5}};
    pat_b = {32{8'h3C}};
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    for (int i = 0; i < 16; i++) mem[i] = {8{32'hDEADBEEF}};
    rstn = 1'b0; clear = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    #1 check_idle_reset("reset");

    // boot cycle with both requesters already asking
    @(negedge clk); rstn = 1'b1; req_valid = 2'b11;
    #1 check("boot_we", W'(rf_we), W'(1'b0));
    check("boot_ready", W'(req_ready), W'(2'b00));

    for (int c = 0; c < 16; c++) begin
      @(negedge clk); #1;
      check("init_addr", W'(rf_addr), W'(c));
      check("init_we", W'(rf_we), W'(1'b1));
      check("init_wdata", rf_wdata, W'(1'b0));
      check("init_ready", W'(req_ready), W'(2'b00));
      check("init_done_low", W'(init_done), W'(1'b0));
    end
    req_valid = 2'b00;

    // cycle 18: serving, idle port holds the last sweep address
    @(negedge clk); #1;
    check("serve_done", W'(init_done), W'(1'b1));
    check("idle_addr_hold", W'(rf_addr), W'(4'd15));
    check("idle_we", W'(rf_we), W'(1'b0));
    for (int i = 0; i < 16; i++) check("zero_fill", mem[i], W'(1'b0));

    // requester 0 writes, requester 1 reads back next cycle
    req_valid = 2'b01; req_we = 2'b01; req_addr = {4'd3, 4'd3}; req_wdata = {W'(1'b0), pat_a};
    #1 check("wr_ready", W'(req_ready), W'(2'b01));
    check("wr_we", W'(rf_we), W'(1'b1));
    check("wr_addr", W'(rf_addr), W'(4'd3));
    check("wr_data", rf_wdata, pat_a);
    @(negedge clk); req_valid = 2'b10; req_we = 2'b00;
    #1 check("rd_ready", W'(req_ready), W'(2'b10));
    check("rd_we", W'(rf_we), W'(1'b0));
    check("wr_no_rsp", W'(rsp_valid), W'(2'b00));
    @(negedge clk); req_valid = 2'b00;
    #1 check("rd_rspv", W'(rsp_valid), W'(2'b10));
    check("rd_rspd", rsp_data, pat_a);
    check("idle_addr_hold2", W'(rf_addr), W'(4'd3));
    @(negedge clk); #1;
    check("rspv_one_cycle", W'(rsp_valid), W'(2'b00));
    check("rspd_hold", rsp_data, pat_a);

    // both valid: strict alternation, response strobe follows each read
    req_addr = {4'd3, 4'd5};
    prev_g = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); req_valid = 2'b11;
      #1 check("rr_grant", W'(req_ready), W'(exp_g[k]));
      check("rr_onehot", W'($countones(req_ready) <= 1), W'(1'b1));
      check("rr_rspv", W'(rsp_valid), W'(prev_g));
      if (k == 2) check("rr_rspd_a", rsp_data, pat_a);
      if (k == 3) check("rr_rspd_0", rsp_data, W'(1'b0));
      prev_g = exp_g[k];
    end

    // requester 1 alone, then both: requester 0 must win
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req_valid = 2'b10;
      #1 check("solo_grant", W'(req_ready), W'(2'b10));
    end
    @(negedge clk); req_valid = 2'b11;
    #1 check("after_solo_grant", W'(req_ready), W'(2'b01));

    // read in cycle k, clear in k+1
    @(negedge clk); req_valid = 2'b10;
    #1 check("pre_clr_grant", W'(req_ready), W'(2'b10));
    @(negedge clk); clear = 1'b1; req_valid = 2'b11;
    #1 check("clr_ready", W'(req_ready), W'(2'b00));
    check("clr_rspv", W'(rsp_valid), W'(2'b10));
    check("clr_rspd", rsp_data, pat_a);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) clear = 1'b0;
      #1 check("reinit_addr", W'(rf_addr), W'(c));
      check("reinit_we", W'(rf_we), W'(1'b1));
      check("reinit_ready", W'(req_ready), W'(2'b00));
    end
    req_valid = 2'b00;
    @(negedge clk); req_valid = 2'b01; req_we = 2'b00; req_addr = {4'd3, 4'd3};
    #1 check("post_clr_grant", W'(req_ready), W'(2'b01));
    @(negedge clk); req_we = 2'b01; req_wdata = {W'(1'b0), pat_b};
    #1 check("post_clr_rspv", W'(rsp_valid), W'(2'b01));
    check("post_clr_rspd", rsp_data, W'(1'b0));
    check("wr2_ready", W'(req_ready), W'(2'b01));
    @(negedge clk); req_valid = 2'b10; req_we = 2'b00;
    #1 check("rd2_ready", W'(req_ready), W'(2'b10));
    @(negedge clk); req_valid = 2'b00; clear = 1'b1;
    #1 check("rd2_rspd", rsp_data, pat_b);

    // reset mid-sweep at counter 7
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) clear = 1'b0;
      #1 check("sweep2_addr", W'(rf_addr), W'(c));
    end
    #1 rstn = 1'b0;
    #1 check_idle_reset("async_rst");
    @(negedge clk);
    @(negedge clk); rstn = 1'b1;
    #1 check("reboot_we", W'(rf_we), W'(1'b0));
    @(negedge clk); #1;
    check("resweep_addr0", W'(rf_addr), W'(4'd0));
    check("resweep_we", W'(rf_we), W'(1'b1));
    @(negedge clk); #1;
    check("resweep_addr1", W'(rf_addr), W'(4'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
